// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp -- multi-port register file with a pending-write scoreboard.
//
//   * NRD asynchronous read ports, two write ports, one issue port.
//   * Register 0 is hard-wired to zero; writes/issues to it are dropped.
//   * BUSY_VEC tracks registers with an outstanding write: set on issue,
//     cleared on commit, issue wins when both hit the same register.
//   * WR_COLLIDE flags a same-address double write one cycle after it.
//
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write
// data (port 1 over port 0) to the read ports.
// ---------------------------------------------------------------------------
module reg_file_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NRD*AW-1:0]   RD_ADDR,
    output logic [NRD*XLEN-1:0] RD_DATA,
    output logic [NRD-1:0]      RD_BUSY,
    input  logic                WR_EN0,
    input  logic [AW-1:0]       WR_ADDR0,
    input  logic [XLEN-1:0]     WR_DATA0,
    input  logic                WR_EN1,
    input  logic [AW-1:0]       WR_ADDR1,
    input  logic [XLEN-1:0]     WR_DATA1,
    input  logic                ISSUE_EN,
    input  logic [AW-1:0]       ISSUE_ADDR,
    output logic [NREGS-1:0]    BUSY_VEC,
    output logic                WR_COLLIDE
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic             collide_q;

    // Qualified requests: address 0 is never a valid target.
    logic we0_ok;
    logic we1_ok;
    logic issue_ok;
    logic collide_now;

    assign we0_ok      = WR_EN0   && (WR_ADDR0   != '0);
    assign we1_ok      = WR_EN1   && (WR_ADDR1   != '0);
    assign issue_ok    = ISSUE_EN && (ISSUE_ADDR != '0);
    assign collide_now = we0_ok && we1_ok && (WR_ADDR0 == WR_ADDR1);

    // Register storage: port 1 overrides port 0 on a shared address.
    // NOTE: the storage array is reset because an asynchronous clear of every
    // register is part of the contract; without that need, leave memories
    // unreset so they can map onto RAM/flop arrays without reset routing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (we1_ok && (WR_ADDR1 == AW'(i)))
                    regs[i] <= WR_DATA1;
                else if (we0_ok && (WR_ADDR0 == AW'(i)))
                    regs[i] <= WR_DATA0;
            end
        end
    end

    // Scoreboard: issue sets, commit clears, issue takes priority.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (issue_ok && (ISSUE_ADDR == AW'(i)))
                    busy_q[i] <= 1'b1;
                else if ((we0_ok && (WR_ADDR0 == AW'(i))) ||
                         (we1_ok && (WR_ADDR1 == AW'(i))))
                    busy_q[i] <= 1'b0;
            end
        end
    end

    // Collision flag: registered copy of this cycle's same-address double write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) collide_q <= 1'b0;
        else     collide_q <= collide_now;
    end

    assign BUSY_VEC   = busy_q;
    assign WR_COLLIDE = collide_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = RD_ADDR[k*AW +: AW];

        // Read port k: stored value and scoreboard bit, optionally forwarded.
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        always_comb begin
            data = regs[addr];
            busy = busy_q[addr];
`ifdef REG_FILE_BYPASS_EN
            // Forwarded data belongs to a completing write, so the register
            // is only busy if a younger issue claims it in the same cycle.
            if (!RST && (addr != '0)) begin
                if (we0_ok && (WR_ADDR0 == addr)) begin
                    data = WR_DATA0;
                    busy = issue_ok && (ISSUE_ADDR == addr);
                end
                if (we1_ok && (WR_ADDR1 == addr)) begin
                    data = WR_DATA1;
                    busy = issue_ok && (ISSUE_ADDR == addr);
                end
            end
`else
            // Without forwarding, reads see stored contents and registered
            // scoreboard state only.
`endif
        end

        assign RD_DATA[k*XLEN +: XLEN] = data;
        assign RD_BUSY[k]              = busy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp -- self-checking bench for reg_file_mp (default parameters).
// Table-driven vectors feed an expected-result queue that is popped at the
// falling edge; hand-written sequences cover reset and mid-cycle corners.
// Expectations follow REG_FILE_BYPASS_EN when the bench is built with it.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic [9:0]  RD_ADDR;
    logic [63:0] RD_DATA;
    logic [1:0]  RD_BUSY;
    logic        WR_EN0;
    logic [4:0]  WR_ADDR0;
    logic [31:0] WR_DATA0;
    logic        WR_EN1;
    logic [4:0]  WR_ADDR1;
    logic [31:0] WR_DATA1;
    logic        ISSUE_EN;
    logic [4:0]  ISSUE_ADDR;
    logic [31:0] BUSY_VEC;
    logic        WR_COLLIDE;

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RD_ADDR    (RD_ADDR),
        .RD_DATA    (RD_DATA),
        .RD_BUSY    (RD_BUSY),
        .WR_EN0     (WR_EN0),
        .WR_ADDR0   (WR_ADDR0),
        .WR_DATA0   (WR_DATA0),
        .WR_EN1     (WR_EN1),
        .WR_ADDR1   (WR_ADDR1),
        .WR_DATA1   (WR_DATA1),
        .ISSUE_EN   (ISSUE_EN),
        .ISSUE_ADDR (ISSUE_ADDR),
        .BUSY_VEC   (BUSY_VEC),
        .WR_COLLIDE (WR_COLLIDE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        we1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        iss;
        logic [4:0]  ia;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_busy;
        logic        e_col;
        logic [31:0] e_bvec;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs [17];
    vec_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic we0, input logic [4:0] a0, input logic [31:0] d0,
        input logic we1, input logic [4:0] a1, input logic [31:0] d1,
        input logic iss, input logic [4:0] ia,
        input logic [4:0] r0, input logic [4:0] r1,
        input logic [31:0] e_rd0, input logic [31:0] e_rd1,
        input logic [1:0] e_busy, input logic e_col, input logic [31:0] e_bvec);
        vec_t v;
        v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.iss = iss; v.ia = ia; v.r0 = r0; v.r1 = r1;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_busy = e_busy;
        v.e_col = e_col; v.e_bvec = e_bvec;
        return v;
    endfunction

    task automatic drive_idle();
        WR_EN0 = 0; WR_ADDR0 = '0; WR_DATA0 = '0;
        WR_EN1 = 0; WR_ADDR1 = '0; WR_DATA1 = '0;
        ISSUE_EN = 0; ISSUE_ADDR = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        WR_EN0 = v.we0; WR_ADDR0 = v.a0; WR_DATA0 = v.d0;
        WR_EN1 = v.we1; WR_ADDR1 = v.a1; WR_DATA1 = v.d1;
        ISSUE_EN = v.iss; ISSUE_ADDR = v.ia;
        RD_ADDR = {v.r1, v.r0};
        sb_q.push_back(v);
    endtask

    task automatic compare_head(input int idx);
        vec_t e;
        if (sb_q.size() == 0) begin
            check($sformatf("v%0d sb_empty", idx), 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("v%0d rd0", idx),   RD_DATA[31:0],      e.e_rd0);
            check($sformatf("v%0d rd1", idx),   RD_DATA[63:32],     e.e_rd1);
            check($sformatf("v%0d busy", idx),  {30'd0, RD_BUSY},   {30'd0, e.e_busy});
            check($sformatf("v%0d col", idx),   {31'd0, WR_COLLIDE}, {31'd0, e.e_col});
            check($sformatf("v%0d bvec", idx),  BUSY_VEC,           e.e_bvec);
        end
    endtask

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Expected values are the state seen before each vector's own edge.
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5,
                      BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 2'b00, 0, 32'h0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 2'b00, 0, 32'h0);
        vecs[2]  = mk(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 5,
                      BYP ? 32'h22 : 32'h0, 32'hDEADBEEF, 2'b00, 0, 32'h0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h22, 32'h22, 2'b00, 1, 32'h0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 32'h22, 32'h0, 2'b00, 0, 32'h0);
        vecs[5]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0,
                      32'h0, 32'h0, 2'b00, 0, 32'h0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 9, 3, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        vecs[8]  = mk(1, 9, 32'h99, 0, 0, 0, 1, 9, 9, 5,
                      BYP ? 32'h99 : 32'h0, 32'hDEADBEEF, 2'b01, 0, 32'h200);
        vecs[9]  = mk(0, 0, 0, 1, 9, 32'hAB, 0, 0, 9, 9,
                      BYP ? 32'hAB : 32'h99, BYP ? 32'hAB : 32'h99,
                      BYP ? 2'b00 : 2'b11, 0, 32'h200);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 32'hAB, 32'h0, 2'b00, 0, 32'h0);
        vecs[11] = mk(1, 1, 32'h1111, 1, 2, 32'h2222, 1, 12, 1, 2,
                      BYP ? 32'h1111 : 32'h0, BYP ? 32'h2222 : 32'h0, 2'b00, 0, 32'h0);
        vecs[12] = mk(1, 31, 32'h31, 0, 0, 0, 1, 12, 1, 2,
                      32'h1111, 32'h2222, 2'b00, 0, 32'h1000);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 31, 32'h0, 32'h31, 2'b01, 0, 32'h1000);
        vecs[14] = mk(1, 12, 32'hC, 1, 12, 32'hD, 0, 0, 12, 0,
                      BYP ? 32'hD : 32'h0, 32'h0, BYP ? 2'b00 : 2'b01, 0, 32'h1000);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 12, 32'hD, 32'hD, 2'b00, 1, 32'h0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 31, 3, 32'h31, 32'h0, 2'b00, 0, 32'h0);

        // Reset held with a write and issue pending: both must be ignored.
        RST = 1'b1;
        RD_ADDR = {5'd4, 5'd4};
        drive_idle();
        WR_EN0 = 1; WR_ADDR0 = 5'd4; WR_DATA0 = 32'hCAFE0004;
        ISSUE_EN = 1; ISSUE_ADDR = 5'd4;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hold rd0", RD_DATA[31:0], 32'h0);
        check("rst_hold bvec", BUSY_VEC, 32'h0);
        check("rst_hold col", {31'd0, WR_COLLIDE}, 32'h0);
        @(negedge CLK);
        drive_idle();
        RST = 1'b0;

        // Every address reads zero on both ports after reset.
        for (int a = 0; a < 32; a++) begin
            RD_ADDR = {5'(31 - a), 5'(a)};
            #1;
            check($sformatf("reset_rd0 a%0d", a), RD_DATA[31:0], 32'h0);
            check($sformatf("reset_rd1 a%0d", 31 - a), RD_DATA[63:32], 32'h0);
            check($sformatf("reset_busy a%0d", a), {30'd0, RD_BUSY}, 32'h0);
        end
        check("reset bvec", BUSY_VEC, 32'h0);
        check("reset col", {31'd0, WR_COLLIDE}, 32'h0);

        // Table vectors: drive after the rising edge, compare at the falling edge.
        @(posedge CLK);
        for (int i = 0; i < 17; i++) begin
            #1;
            drive_vec(vecs[i]);
            @(negedge CLK);
            compare_head(i);
            @(posedge CLK);
        end
        #1;
        drive_idle();
        check("sb drained", sb_q.size(), 32'd0);

        // Load r3, mark r4 busy, then a same-address double write on r8.
        WR_EN0 = 1; WR_ADDR0 = 5'd3; WR_DATA0 = 32'h55;
        ISSUE_EN = 1; ISSUE_ADDR = 5'd4;
        @(posedge CLK);
        #1;
        drive_idle();
        WR_EN0 = 1; WR_ADDR0 = 5'd8; WR_DATA0 = 32'h1;
        WR_EN1 = 1; WR_ADDR1 = 5'd8; WR_DATA1 = 32'h2;
        @(posedge CLK);
        #1;
        drive_idle();
        RD_ADDR = {5'd8, 5'd3};
        #1;
        check("pre_rst rd3", RD_DATA[31:0], 32'h55);
        check("pre_rst rd8", RD_DATA[63:32], 32'h2);
        check("pre_rst col", {31'd0, WR_COLLIDE}, 32'h1);
        check("pre_rst bvec", BUSY_VEC, 32'h10);

        // Mid-cycle reset with a write pending: clears at once, drops the write.
        WR_EN0 = 1; WR_ADDR0 = 5'd6; WR_DATA0 = 32'h66;
        RD_ADDR = {5'd6, 5'd3};
        #1;
        RST = 1'b1;
        #1;
        check("async_rst rd3", RD_DATA[31:0], 32'h0);
        check("async_rst rd6", RD_DATA[63:32], 32'h0);
        check("async_rst bvec", BUSY_VEC, 32'h0);
        check("async_rst col", {31'd0, WR_COLLIDE}, 32'h0);
        @(posedge CLK);
        #1;
        check("rst_edge rd6", RD_DATA[63:32], 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_release rd6", RD_DATA[63:32], BYP ? 32'h66 : 32'h0);
        @(posedge CLK);
        #1;
        drive_idle();
        #1;
        check("first_commit rd6", RD_DATA[63:32], 32'h66);
        check("first_commit rd3", RD_DATA[31:0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
